uart_rx: RTL and testbench

//  Serial UART receiver; counterpart of the transmitter on the same link.

---
 rtl/uart_rx_if.sv | 22 ++
 rtl/uart_rx.sv | 164 ++++++++++++++++
 tb/tb_uart_rx.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Receiver-side bundle: 16x tick and serial line in; word, done strobe and error flags out.
// The receiver has no backpressure; the host must capture dout on rx_done.
interface uart_rx_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  s_tick;
  logic                  rx;
  logic [DATA_WIDTH-1:0] dout;
  logic                  rx_done;
  logic                  parity_err;
  logic                  frame_err;

  modport master (
    output s_tick, rx,
    input  dout, rx_done, parity_err, frame_err
  );

  modport slave (
    input  s_tick, rx,
    output dout, rx_done, parity_err, frame_err
  );
endinterface

// File: rtl/uart_rx.sv
// 16x-oversampling UART receiver: start/data(LSB first)/optional parity/stop -> parallel word.
// rx_done fires one clk after the final stop sample (2-clk sync latency on rx); no backpressure.
module uart_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BIT   = 1,
  parameter int PARITY     = 0
) (
  input  logic       clk,
  input  logic       rst,
  uart_rx_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  localparam logic [3:0] LAST_DATA  = 4'(DATA_WIDTH - 1);
  localparam logic [3:0] LAST_STOP  = 4'(STOP_BIT - 1);
  localparam bit         HAS_PARITY = (PARITY != 0);
  localparam bit         ODD_PARITY = (PARITY == 1);

  state_e                state_q, state_d;
  logic                  rx_meta_q, rx_s_q;
  logic [3:0]            tick_q, tick_d;
  logic [3:0]            bit_q, bit_d;
  logic [DATA_WIDTH-1:0] sreg_q, sreg_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  perr_pend_q, perr_pend_d;
  logic                  ferr_pend_q, ferr_pend_d;
  logic                  rx_done_q, rx_done_d;
  logic                  parity_err_q, parity_err_d;
  logic                  frame_err_q, frame_err_d;
  logic                  ferr_now;

  // A low stop sample in this cycle must reach the flags of the completing frame.
  assign ferr_now = ferr_pend_q | ~rx_s_q;

  always_comb begin
    state_d      = state_q;
    tick_d       = tick_q;
    bit_d        = bit_q;
    sreg_d       = sreg_q;
    dout_d       = dout_q;
    perr_pend_d  = perr_pend_q;
    ferr_pend_d  = ferr_pend_q;
    rx_done_d    = 1'b0;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;

    case (state_q)
      S_IDLE: begin
        if (!rx_s_q) begin
          state_d = S_START;
          tick_d  = 4'd0;
        end
      end
      S_START: begin
        if (bus.s_tick) begin
          if (tick_q == 4'd7) begin
            if (!rx_s_q) begin
              state_d     = S_DATA;
              tick_d      = 4'd0;
              bit_d       = 4'd0;
              perr_pend_d = 1'b0;
              ferr_pend_d = 1'b0;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            tick_d = tick_q + 4'd1;
          end
        end
      end
      S_DATA: begin
        if (bus.s_tick) begin
          if (tick_q == 4'd15) begin
            tick_d = 4'd0;
            sreg_d = {rx_s_q, sreg_q[DATA_WIDTH-1:1]};
            if (bit_q == LAST_DATA) begin
              bit_d   = 4'd0;
              state_d = HAS_PARITY ? S_PARITY : S_STOP;
            end else begin
              bit_d = bit_q + 4'd1;
            end
          end else begin
            tick_d = tick_q + 4'd1;
          end
        end
      end
      S_PARITY: begin
        if (bus.s_tick) begin
          if (tick_q == 4'd15) begin
            tick_d      = 4'd0;
            perr_pend_d = ((^sreg_q) ^ rx_s_q) != ODD_PARITY;
            state_d     = S_STOP;
          end else begin
            tick_d = tick_q + 4'd1;
          end
        end
      end
      S_STOP: begin
        if (bus.s_tick) begin
          if (tick_q == 4'd15) begin
            tick_d = 4'd0;
            if (bit_q == LAST_STOP) begin
              bit_d        = 4'd0;
              state_d      = S_IDLE;
              rx_done_d    = 1'b1;
              dout_d       = sreg_q;
              parity_err_d = perr_pend_q;
              frame_err_d  = ferr_now;
            end else begin
              bit_d       = bit_q + 4'd1;
              ferr_pend_d = ferr_now;
            end
          end else begin
            tick_d = tick_q + 4'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      tick_q       <= 4'd0;
      bit_q        <= 4'd0;
      sreg_q       <= '0;
      dout_q       <= '0;
      perr_pend_q  <= 1'b0;
      ferr_pend_q  <= 1'b0;
      rx_done_q    <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      rx_meta_q    <= bus.rx;
      rx_s_q       <= rx_meta_q;
      tick_q       <= tick_d;
      bit_q        <= bit_d;
      sreg_q       <= sreg_d;
      dout_q       <= dout_d;
      perr_pend_q  <= perr_pend_d;
      ferr_pend_q  <= ferr_pend_d;
      rx_done_q    <= rx_done_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.rx_done    = rx_done_q;
  assign bus.parity_err = parity_err_q;
  assign bus.frame_err  = frame_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: one no-parity receiver and one even-parity receiver on a shared line.
// Expected words and flags are hand-derived from the frames driven.
module tb_uart_rx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx_line = 1'b1;
  logic s_tick = 1'b0;
  int   tick_div = 1;
  int   tick_ph = 0;

  int checks = 0;
  int failures = 0;

  uart_rx_if #(.DATA_WIDTH(8)) bus0 ();
  uart_rx_if #(.DATA_WIDTH(8)) bus1 ();

  assign bus0.rx     = rx_line;
  assign bus0.s_tick = s_tick;
  assign bus1.rx     = rx_line;
  assign bus1.s_tick = s_tick;

  uart_rx #(.DATA_WIDTH(8), .STOP_BIT(1), .PARITY(0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  uart_rx #(.DATA_WIDTH(8), .STOP_BIT(1), .PARITY(2)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      tick_ph = (tick_ph + 1) % tick_div;
      s_tick  = (tick_ph == 0);
    end
  end

  // Strobe monitor, sampled on the falling edge.
  int         done0 = 0;
  int         done1 = 0;
  int         wide0 = 0;
  int         perr0_seen = 0;
  logic       prev0 = 1'b0;
  logic [7:0] q0[$];
  logic [7:0] last1 = 8'h00;

  always @(negedge clk) begin
    if (bus0.rx_done) begin
      done0 = done0 + 1;
      q0.push_back(bus0.dout);
    end
    if (bus0.rx_done && prev0) wide0 = wide0 + 1;
    prev0 = bus0.rx_done;
    if (bus0.parity_err) perr0_seen = perr0_seen + 1;
    if (bus1.rx_done) begin
      done1 = done1 + 1;
      last1 = bus1.dout;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic v);
    rx_line = v;
    idle(16 * tick_div);
  endtask

  // Holds the bit for a full bit time but pulses reset in its middle.
  task automatic drive_bit_abort(input logic v);
    rx_line = v;
    idle(8 * tick_div);
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(8 * tick_div - 3);
  endtask

  task automatic send_frame(input logic [7:0] data, input int par, input logic stop_v,
                            input int abort_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i == abort_bit) drive_bit_abort(data[i]);
      else                drive_bit(data[i]);
    end
    if (par >= 0) drive_bit(1'(par));
    drive_bit(stop_v);
  endtask

  int base0;
  int base1;
  int qbase;

  initial begin
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(200);
    check("reset_done0",  32'(done0), 32'd0);
    check("reset_done1",  32'(done1), 32'd0);
    check("reset_dout",   32'(bus0.dout), 32'h00);
    check("reset_perr",   32'(bus0.parity_err), 32'd0);
    check("reset_ferr",   32'(bus0.frame_err), 32'd0);

    // Plain frame, s_tick every clock.
    base0 = done0;
    send_frame(8'hA5, -1, 1'b1, -1);
    idle(48);
    check("a5_count", 32'(done0 - base0), 32'd1);
    check("a5_dout",  32'(q0[q0.size()-1]), 32'hA5);
    check("a5_perr",  32'(bus0.parity_err), 32'd0);
    check("a5_ferr",  32'(bus0.frame_err), 32'd0);

    // Short low glitch must be rejected at the mid start-bit sample.
    base0 = done0;
    base1 = done1;
    rx_line = 1'b0;
    idle(4);
    rx_line = 1'b1;
    idle(48);
    check("glitch_done0", 32'(done0 - base0), 32'd0);
    check("glitch_done1", 32'(done1 - base1), 32'd0);
    send_frame(8'h3C, -1, 1'b1, -1);
    idle(48);
    check("3c_count", 32'(done0 - base0), 32'd1);
    check("3c_dout",  32'(q0[q0.size()-1]), 32'h3C);

    // Bad stop bit, then a clean frame clears the flag.
    base0 = done0;
    send_frame(8'h55, -1, 1'b0, -1);
    rx_line = 1'b1;
    idle(48);
    check("ferr_count", 32'(done0 - base0), 32'd1);
    check("ferr_dout",  32'(q0[q0.size()-1]), 32'h55);
    check("ferr_flag",  32'(bus0.frame_err), 32'd1);
    send_frame(8'h55, -1, 1'b1, -1);
    idle(48);
    check("ferr_clr_count", 32'(done0 - base0), 32'd2);
    check("ferr_clr_flag",  32'(bus0.frame_err), 32'd0);

    // Even parity: 0x07 has three ones, so the correct parity bit is 1.
    base1 = done1;
    send_frame(8'h07, 0, 1'b1, -1);
    idle(48);
    check("par_bad_count", 32'(done1 - base1), 32'd1);
    check("par_bad_dout",  32'(last1), 32'h07);
    check("par_bad_flag",  32'(bus1.parity_err), 32'd1);
    check("par_bad_ferr",  32'(bus1.frame_err), 32'd0);
    send_frame(8'h07, 1, 1'b1, -1);
    idle(48);
    check("par_ok_count", 32'(done1 - base1), 32'd2);
    check("par_ok_dout",  32'(last1), 32'h07);
    check("par_ok_flag",  32'(bus1.parity_err), 32'd0);

    // Back-to-back frames at 1-in-4 ticks, third frame aborted by reset.
    tick_div = 4;
    idle(128);
    base0 = done0;
    qbase = q0.size();
    send_frame(8'h00, -1, 1'b1, -1);
    send_frame(8'hFF, -1, 1'b1, -1);
    send_frame(8'hF0, -1, 1'b1, 5);
    idle(300);
    check("b2b_count", 32'(done0 - base0), 32'd2);
    if (q0.size() >= qbase + 2) begin
      check("b2b_first",  32'(q0[qbase]), 32'h00);
      check("b2b_second", 32'(q0[qbase+1]), 32'hFF);
    end else begin
      check("b2b_pulses", 32'(q0.size() - qbase), 32'd2);
    end
    check("abort_dout",   32'(bus0.dout), 32'h00);
    check("done_width",   32'(wide0), 32'd0);
    check("noparity_err", 32'(perr0_seen), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
